rc4_keystream_packer: RTL and testbench
=======================================

Name: rc4_keystream_packer

Overview:
- Downstream stage of the SPECK-hash/RC4 datapath top.
- After RC4 keystream generation completes, walks the RC4 result memory through its 4-bit read address (`add_to_read`) and captures each 4-bit `out` nibble.
- Packs 16 nibbles into one 64-bit word, then presents it on a valid/ready handshake to the next consumer, e.g. a block cipher XOR or a bus register.
- Decouples the nibble-serial RC4 read port from word-wide consumers.

Parameters:
- NIBBLES, 16, number of nibbles read per word; sets the address range 0..NIBBLES-1. Fixed at 16 in this design (64-bit word, 4-bit address).
- RD_LAT, 1, cycles from driving `rd_addr` to valid `rd_data`; legal range 0..3.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: RC4 memory contents are final, begin collection.
- rd_addr  output  4  read address to the RC4 datapath `add_to_read`.
- rd_en  output  1  high in every cycle `rd_addr` carries a live request.
- rd_data  input  4  RC4 datapath `out`, valid RD_LAT cycles after its address.
- busy  output  1  high from the cycle after accepted start until the handshake completes.
- word  output  64  packed keystream; nibble read from address i occupies bits [4i+3:4i].
- word_valid  output  1  word is complete and stable.
- word_ready  input  1  consumer accepts word.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE
  - rd_addr=0, rd_en=0, busy=0
  - word=64'h0, word_valid=0
  - address counter and latency-tag pipeline cleared
- Reset asserted mid-operation aborts the operation immediately; no partial word is ever flagged valid.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - start=1 -> ISSUE, clear word register and address counter.
  - Other inputs are ignored.
- ISSUE:
  - rd_en=1; rd_addr = counter, which increments by 1 each cycle from 0.
  - When the counter = NIBBLES-1: go to DRAIN if RD_LAT>0, else HOLD.
  - Exactly NIBBLES consecutive addresses are issued, no gaps.
- Capture:
  - A tag pipeline of depth RD_LAT carries {valid, addr}.
  - When a tag emerges valid, rd_data is written into word[4*addr+3:4*addr]; other nibbles are unchanged.
  - With RD_LAT=0, rd_data is captured in the same cycle its address is driven.
- DRAIN:
  - rd_en=0, rd_addr holds its last value.
  - Leave for HOLD on the cycle the last nibble (addr NIBBLES-1) is captured.
- HOLD:
  - word_valid=1; word is stable and not modified.
  - word_valid && word_ready -> IDLE, word_valid=0 next cycle.
  - word retains its value in IDLE until the next start.
- Latency: start at cycle 0 -> addr 0 driven at cycle 1 -> word_valid first high at cycle NIBBLES+RD_LAT+1 (18 with defaults).
- Throughput: one word per NIBBLES+RD_LAT+2 cycles minimum.
- busy = (state != IDLE).
- start while busy (including the handshake cycle) is ignored and not queued.
- word_ready while word_valid=0 has no effect.
- The address counter stops at NIBBLES-1 and never wraps within an operation.

Optional Feature:
- Macro: RC4_PACKER_XOR_EN.
- Defined:
  - Adds input `plain` [63:0], sampled on the start cycle.
  - word = packed keystream XOR the latched `plain`, applied at the HOLD entry register.
  - word_valid timing is unchanged.
- Not defined:
  - No `plain` port.
  - word is the raw keystream.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, HOLD=2'd3
  - NIBBLE_W=4, WORD_W=64, ADDR_W=4
- One natural sub-module: rc4_rd_lat_pipe, a parameterised RD_LAT-deep {valid, addr} delay line with asynchronous active-low reset.
- FSM, counter and packing register stay in the top.

Test Plan:
- Basic collection:
  - Stimulus: memory model with RD_LAT=1 returning nibble = addr; start pulse; word_ready=1.
  - Response: word=64'hFEDCBA9876543210; word_valid high exactly at cycle 18 for one cycle; busy falls the cycle after.
- Consumer backpressure:
  - Stimulus: word_ready=0 for 10 cycles after word_valid.
  - Response: word and word_valid held stable for all 10 cycles; IDLE the cycle after word_ready rises.
- Start while busy:
  - Stimulus: start pulses at cycles 5 and during HOLD.
  - Response: exactly NIBBLES rd_en cycles; no second operation; word unchanged.
- Reset mid-operation:
  - Stimulus: reset low at cycle 9, restart afterwards.
  - Response: all outputs at reset values asynchronously; after restart, word matches a fresh read, with no stale nibbles from the aborted run.
- Latency sweep:
  - Stimulus: RD_LAT=0 and RD_LAT=3, memory returning ~addr.
  - Response: word=64'h0123456789ABCDEF; word_valid at cycles 17 and 20 respectively.
- XOR option (RC4_PACKER_XOR_EN defined):
  - Stimulus: plain=64'hFFFFFFFFFFFFFFFF, memory returning addr.
  - Response: word=64'h0123456789ABCDEF.

Source files
------------

// File: rtl/rc4_keystream_packer_pkg.sv
// Shared types and widths for the RC4 keystream packer.
package rc4_keystream_packer_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned WORD_W   = 64;
  localparam int unsigned ADDR_W   = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StHold  = 2'd3
  } state_e;

endpackage

// File: rtl/rc4_keystream_packer_if.sv
// RC4 read port plus packed-word valid/ready handshake.
// RC4_PACKER_XOR_EN adds the plaintext input carried with the start pulse.
interface rc4_keystream_packer_if;
  import rc4_keystream_packer_pkg::*;

  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_en;
  logic [NIBBLE_W-1:0] rd_data;
  logic [WORD_W-1:0]   word;
  logic                word_valid;
  logic                word_ready;
`ifdef RC4_PACKER_XOR_EN
  logic [WORD_W-1:0]   plain;

  modport master (
    output rd_addr, rd_en, word, word_valid,
    input  rd_data, word_ready, plain
  );
  modport slave (
    input  rd_addr, rd_en, word, word_valid,
    output rd_data, word_ready, plain
  );
`else
  modport master (
    output rd_addr, rd_en, word, word_valid,
    input  rd_data, word_ready
  );
  modport slave (
    input  rd_addr, rd_en, word, word_valid,
    output rd_data, word_ready
  );
`endif

endinterface

// File: rtl/rc4_keystream_packer_rd_lat_pipe.sv
// Depth-deep {valid, addr} delay line matching the RC4 read latency.
module rc4_rd_lat_pipe #(
  parameter int unsigned Depth = 1,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [AddrW-1:0] addr_i,
  output logic             valid_o,
  output logic [AddrW-1:0] addr_o
);

  if (Depth == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign addr_o  = addr_i;
  end else begin : g_pipe
    logic [Depth-1:0] valid_q, valid_d;
    logic [AddrW-1:0] addr_q [Depth];
    logic [AddrW-1:0] addr_d [Depth];

    always_comb begin
      valid_d[0] = valid_i;
      addr_d[0]  = addr_i;
      for (int i = 1; i < Depth; i++) begin
        valid_d[i] = valid_q[i-1];
        addr_d[i]  = addr_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int i = 0; i < Depth; i++) addr_q[i] <= '0;
      end else begin
        valid_q <= valid_d;
        for (int i = 0; i < Depth; i++) addr_q[i] <= addr_d[i];
      end
    end

    assign valid_o = valid_q[Depth-1];
    assign addr_o  = addr_q[Depth-1];
  end

endmodule

// File: rtl/rc4_keystream_packer.sv
// Walks the RC4 result memory, packs 16 nibbles into a 64-bit word, offers it on valid/ready.
// Optional RC4_PACKER_XOR_EN: XOR the word with plaintext latched at start.
module rc4_keystream_packer
  import rc4_keystream_packer_pkg::*;
#(
  parameter int unsigned NIBBLES = 16,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  rc4_keystream_packer_if.master        bus
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NIBBLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] word_cap;
  logic              cap_valid;
  logic [ADDR_W-1:0] cap_addr;
  logic              capturing;

  rc4_rd_lat_pipe #(
    .Depth (RD_LAT),
    .AddrW (ADDR_W)
  ) u_lat_pipe (
    .clk_i   (clk),
    .rst_ni  (reset),
    .valid_i (bus.rd_en),
    .addr_i  (cnt_q),
    .valid_o (cap_valid),
    .addr_o  (cap_addr)
  );

`ifdef RC4_PACKER_XOR_EN
  logic [WORD_W-1:0] plain_q, plain_d;

  always_comb begin
    plain_d = plain_q;
    if (state_q == StIdle && start) plain_d = bus.plain;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) plain_q <= '0;
    else        plain_q <= plain_d;
  end
`endif

  assign capturing = cap_valid && (state_q == StIssue || state_q == StDrain);

  always_comb begin
    word_cap = word_q;
    if (capturing) word_cap[NIBBLE_W*cap_addr +: NIBBLE_W] = bus.rd_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          cnt_d   = '0;
          word_d  = '0;
        end
      end
      StIssue: begin
        word_d = word_cap;
        if (cnt_q == LastAddr) state_d = (RD_LAT > 0) ? StDrain : StHold;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      StDrain: begin
        word_d = word_cap;
        if (capturing && cap_addr == LastAddr) state_d = StHold;
      end
      StHold: begin
        if (bus.word_ready) state_d = StIdle;
      end
    endcase
`ifdef RC4_PACKER_XOR_EN
    // Plaintext is folded in only once, as the completed word enters HOLD.
    if (state_d == StHold && state_q != StHold) word_d = word_cap ^ plain_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  assign bus.rd_addr    = cnt_q;
  assign bus.rd_en      = (state_q == StIssue);
  assign bus.word       = word_q;
  assign bus.word_valid = (state_q == StHold);
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_rc4_keystream_packer.sv
// Directed bench for rc4_keystream_packer at read latencies 1, 0 and 3.
module tb_rc4_keystream_packer;

  logic clk = 1'b0;
  logic reset;
  logic start1, start0, start3;
  logic busy1, busy0, busy3;
  logic ready1, ready0, ready3;
  int   mode;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rc4_keystream_packer_if bus1 ();
  rc4_keystream_packer_if bus0 ();
  rc4_keystream_packer_if bus3 ();

  rc4_keystream_packer #(.NIBBLES(16), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .bus(bus1));
  rc4_keystream_packer #(.NIBBLES(16), .RD_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .bus(bus0));
  rc4_keystream_packer #(.NIBBLES(16), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .busy(busy3), .bus(bus3));

  function automatic logic [3:0] pat(input logic [3:0] a);
    case (mode)
      1:       pat = ~a;
      2:       pat = a ^ 4'h5;
      default: pat = a;
    endcase
  endfunction

  // Memory models: data appears RD_LAT cycles after its address.
  logic [3:0] m1_q;
  logic [3:0] m3_q [3];
  always_ff @(posedge clk) begin
    m1_q    <= pat(bus1.rd_addr);
    m3_q[0] <= pat(bus3.rd_addr);
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign bus1.rd_data    = m1_q;
  assign bus0.rd_data    = pat(bus0.rd_addr);
  assign bus3.rd_data    = m3_q[2];
  assign bus1.word_ready = ready1;
  assign bus0.word_ready = ready0;
  assign bus3.word_ready = ready3;

`ifdef RC4_PACKER_XOR_EN
  logic [63:0] plain1;
  assign bus1.plain = plain1;
  assign bus0.plain = 64'h0;
  assign bus3.plain = 64'h0;
`endif

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus1.rd_addr !== 4'h0 || bus1.rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd: addr=%h en=%b want 0/0", bus1.rd_addr, bus1.rd_en);
    end
    n_checks++;
    if (busy1 !== 1'b0 || bus1.word_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b valid=%b want 0/0", busy1, bus1.word_valid);
    end
    n_checks++;
    if (bus1.word !== 64'h0) begin
      n_fail++; $display("FAIL reset_word: got %h want 0", bus1.word);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int first_v = -1;
    int nvalid = 0;
    int nrd = 0;
    mode = 0; ready1 = 1'b1;
    start1 = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (bus1.rd_en) nrd++;
      if (n == 1) begin
        n_checks++;
        if (bus1.rd_addr !== 4'h0 || busy1 !== 1'b1) begin
          n_fail++; $display("FAIL basic_first: addr=%h busy=%b want 0/1", bus1.rd_addr, busy1);
        end
      end
      if (bus1.word_valid) begin
        nvalid++;
        if (first_v < 0) first_v = n;
        n_checks++;
        if (bus1.word !== 64'hFEDCBA9876543210) begin
          n_fail++; $display("FAIL basic_word: got %h want FEDCBA9876543210", bus1.word);
        end
      end
      if (n == 19) begin
        n_checks++;
        if (busy1 !== 1'b0) begin
          n_fail++; $display("FAIL basic_busy_fall: busy=%b want 0", busy1);
        end
      end
    end
    n_checks++;
    if (first_v != 18) begin n_fail++; $display("FAIL basic_latency: got %0d want 18", first_v); end
    n_checks++;
    if (nvalid != 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d want 1", nvalid); end
    n_checks++;
    if (nrd != 16) begin n_fail++; $display("FAIL basic_rd_en: got %0d want 16", nrd); end
  endtask

  task automatic test_backpressure();
    bit found = 0;
    mode = 2; ready1 = 1'b0;
    start1 = 1'b1;
    for (int n = 1; n <= 40 && !found; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (bus1.word_valid) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL bp_timeout: valid=%b want 1 within 40 cycles", bus1.word_valid);
    end else begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        n_checks++;
        if (bus1.word_valid !== 1'b1 || bus1.word !== 64'hAB89EFCD23016745) begin
          n_fail++;
          $display("FAIL bp_hold%0d: valid=%b word=%h want 1/AB89EFCD23016745",
                   k, bus1.word_valid, bus1.word);
        end
      end
      ready1 = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy1 !== 1'b0 || bus1.word_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_release: busy=%b valid=%b want 0/0", busy1, bus1.word_valid);
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit found = 0;
    int nrd = 0;
    mode = 0; ready1 = 1'b0;
    start1 = 1'b1;
    for (int n = 1; n <= 40 && !found; n++) begin
      @(negedge clk);
      start1 = (n == 5);
      if (bus1.rd_en) nrd++;
      if (bus1.word_valid) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL swb_timeout: valid=%b want 1 within 40 cycles", bus1.word_valid);
    end
    // Second start lands on the handshake cycle itself.
    start1 = 1'b1; ready1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (bus1.rd_en) nrd++;
      @(negedge clk);
    end
    n_checks++;
    if (nrd != 16) begin n_fail++; $display("FAIL swb_rd_en: got %0d want 16", nrd); end
    n_checks++;
    if (busy1 !== 1'b0 || bus1.word !== 64'hFEDCBA9876543210) begin
      n_fail++; $display("FAIL swb_idle: busy=%b word=%h want 0/FEDCBA9876543210", busy1, bus1.word);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    mode = 0; ready1 = 1'b1;
    start1 = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus1.rd_en !== 1'b0 || bus1.rd_addr !== 4'h0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: en=%b addr=%h busy=%b want 0/0/0", bus1.rd_en, bus1.rd_addr, busy1);
    end
    n_checks++;
    if (bus1.word !== 64'h0 || bus1.word_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_word: word=%h valid=%b want 0/0", bus1.word, bus1.word_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    mode = 2;
    @(negedge clk);
    start1 = 1'b1;
    for (int n = 1; n <= 40 && !found; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (bus1.word_valid) found = 1;
    end
    n_checks++;
    if (bus1.word_valid !== 1'b1 || bus1.word !== 64'hAB89EFCD23016745) begin
      n_fail++;
      $display("FAIL midrst_fresh: valid=%b word=%h want 1/AB89EFCD23016745",
               bus1.word_valid, bus1.word);
    end
    @(negedge clk);
  endtask

  task automatic test_latency_sweep();
    int first0 = -1;
    int first3 = -1;
    mode = 1; ready0 = 1'b1; ready3 = 1'b1;
    start0 = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (bus0.word_valid && first0 < 0) begin
        first0 = n;
        n_checks++;
        if (bus0.word !== 64'h0123456789ABCDEF) begin
          n_fail++; $display("FAIL lat0_word: got %h want 0123456789ABCDEF", bus0.word);
        end
      end
    end
    n_checks++;
    if (first0 != 17) begin n_fail++; $display("FAIL lat0_latency: got %0d want 17", first0); end
    start3 = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (bus3.word_valid && first3 < 0) begin
        first3 = n;
        n_checks++;
        if (bus3.word !== 64'h0123456789ABCDEF) begin
          n_fail++; $display("FAIL lat3_word: got %h want 0123456789ABCDEF", bus3.word);
        end
      end
    end
    n_checks++;
    if (first3 != 20) begin n_fail++; $display("FAIL lat3_latency: got %0d want 20", first3); end
  endtask

`ifdef RC4_PACKER_XOR_EN
  task automatic test_xor();
    int first_v = -1;
    mode = 0; ready1 = 1'b1;
    plain1 = 64'hFFFFFFFFFFFFFFFF;
    start1 = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      plain1 = 64'h0;
      if (bus1.word_valid && first_v < 0) begin
        first_v = n;
        n_checks++;
        if (bus1.word !== 64'h0123456789ABCDEF) begin
          n_fail++; $display("FAIL xor_word: got %h want 0123456789ABCDEF", bus1.word);
        end
      end
    end
    n_checks++;
    if (first_v != 18) begin n_fail++; $display("FAIL xor_latency: got %0d want 18", first_v); end
  endtask
`endif

  initial begin
    mode = 0;
    start1 = 1'b0; start0 = 1'b0; start3 = 1'b0;
    ready1 = 1'b0; ready0 = 1'b0; ready3 = 1'b0;
`ifdef RC4_PACKER_XOR_EN
    plain1 = 64'h0;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_latency_sweep();
`ifdef RC4_PACKER_XOR_EN
    test_xor();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
